// File: rtl/pixel_readout_pkg.sv
// Shared geometry and types for the pixel readout path.
// Column/row/data widths are fixed here so the pixel record is one packed type everywhere.
package readout_pkg;
  localparam int DATA_W = 8;
  localparam int NCOL   = 2;
  localparam int NROW   = 2;
  localparam int DEPTH  = 8;
  localparam int COL_W  = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int ROW_W  = (NROW > 1) ? $clog2(NROW) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              last;
  } pixel_t;

  typedef enum logic {IDLE, SHIFT} state_e;

  function automatic logic is_last(logic [ROW_W-1:0] row, logic [COL_W-1:0] col);
    return (row == ROW_W'(NROW - 1)) && (col == COL_W'(NCOL - 1));
  endfunction
endpackage

// File: rtl/pixel_readout_if.sv
// Tagged-pixel valid/ready stream from the readout block to the frame sink.
interface pixel_readout_if;
  import readout_pkg::*;

  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic [ROW_W-1:0]  pix_row;
  logic [COL_W-1:0]  pix_col;
  logic              pix_last;

  modport master (output pix_valid, pix_data, pix_row, pix_col, pix_last, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_row, pix_col, pix_last, output pix_ready);
endinterface

// File: rtl/pixel_readout_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rd_data = mem_q[rd_ptr_q];

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/pixel_readout.sv
// Captures a row of column ADC words on each adc rising edge and streams them
// out one tagged pixel per cycle through a small FIFO.
module pixel_readout
  import readout_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   nre1,
  input  logic                   nre2,
  input  logic                   adc,
  input  logic                   erase,
  input  logic [NCOL*DATA_W-1:0] adc_data,
  pixel_readout_if.master        pix,
  output logic                   frame_done,
  output logic                   sel_err,
  output logic                   ovf_err
);
  state_e                  state_q, state_d;
  logic [NCOL*DATA_W-1:0]  stage_q, stage_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic adc_q, sel_err_q, sel_err_d, ovf_err_q, ovf_err_d, frame_done_q, frame_done_d;
  logic adc_event, pop, push, fifo_full, fifo_empty;
  pixel_t push_pix, head;

  assign adc_event = adc & ~adc_q;
  assign pop       = ~fifo_empty & pix.pix_ready;

  assign push_pix.data = stage_q[int'(col_q)*DATA_W +: DATA_W];
  assign push_pix.row  = row_q;
  assign push_pix.col  = col_q;
  assign push_pix.last = is_last(row_q, col_q);

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    row_d        = row_q;
    col_d        = col_q;
    sel_err_d    = sel_err_q;
    ovf_err_d    = ovf_err_q;
    push         = 1'b0;
    frame_done_d = pop & head.last & ~erase;
    if (erase) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (adc_event) begin
          if (nre1 != nre2) begin
            stage_d = adc_data;
            row_d   = ROW_W'(nre1);  // nre1 high means nre2 is the active row
            col_d   = '0;
            state_d = SHIFT;
          end else begin
            sel_err_d = 1'b1;
          end
        end
        SHIFT: begin
          push  = 1'b1;
          col_d = col_q + COL_W'(1);
          if ((fifo_full && !pop) || adc_event) ovf_err_d = 1'b1;
          if (col_q == COL_W'(NCOL - 1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      adc_q        <= 1'b0;
      sel_err_q    <= 1'b0;
      ovf_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      row_q        <= row_d;
      col_q        <= col_d;
      adc_q        <= adc;
      sel_err_q    <= sel_err_d;
      ovf_err_q    <= ovf_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  sync_fifo #(.WIDTH($bits(pixel_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (erase),
    .wr_data (push_pix),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pix.pix_valid = ~fifo_empty;
  assign pix.pix_data  = head.data;
  assign pix.pix_row   = head.row;
  assign pix.pix_col   = head.col;
  assign pix.pix_last  = head.last;
  assign frame_done    = frame_done_q;
  assign sel_err       = sel_err_q;
  assign ovf_err       = ovf_err_q;
endmodule
